// File: rtl/pdm_dec_pkg.sv
// rtl/pdm_dec_pkg.sv - shared widths, saturation helper and PDM polarity constants
package pdm_dec_pkg;

    localparam int PDM_POS = 1;
    localparam int PDM_NEG = -1;

    function automatic int cic_width(input int r);
        return 3 * $clog2(r) + 2;
    endfunction

    // Clamp a signed value into the two's complement range of a bits-wide word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/pdm_cic_comb.sv
// rtl/pdm_cic_comb.sv - one CIC differentiator stage stepping on an event enable
module pdm_cic_comb
    import pdm_dec_pkg::*;
#(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] dly_q;
    logic [W-1:0] dly_d;
    logic [W-1:0] out_q;
    logic [W-1:0] out_d;

    always_comb begin
        dly_d = dly_q;
        out_d = out_q;
        if (en) begin
            out_d = din - dly_q;
            dly_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '0;
            out_q <= '0;
        end else begin
            dly_q <= dly_d;
            out_q <= out_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - third-order CIC PDM-to-PCM decimator; PDM_DEC_DCBLOCK_EN adds a DC blocker
module pdm_cic_decimator
    import pdm_dec_pkg::*;
#(
    parameter int R        = 64,
    parameter int OUT_BITS = 16,
    parameter int DC_SHIFT = 10
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       PDM_IN,
    input  logic                       IN_EN,
    output logic signed [OUT_BITS-1:0] PCM_DATA,
    output logic                       PCM_VALID,
    input  logic                       PCM_READY,
    output logic                       OVERRUN
);

    localparam int L     = $clog2(R);
    localparam int W     = cic_width(R);
    localparam int SHIFT = 3 * L + 1 - OUT_BITS;
`ifdef PDM_DEC_DCBLOCK_EN
    localparam int PD    = 4;
`else
    localparam int PD    = 3;
`endif
    localparam logic signed [W-1:0] STEP_POS = W'(PDM_POS);
    localparam logic signed [W-1:0] STEP_NEG = W'(PDM_NEG);

    if (R < 8 || R > 256 || (R & (R - 1)) != 0 || 3 * L + 1 < OUT_BITS || DC_SHIFT < 1) begin : g_bad_cfg
        $error("pdm_cic_decimator: unsupported parameter set");
    end

    logic signed [W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [L-1:0]        cnt_q, cnt_d;
    logic                ev;
    logic [PD-1:0]       evp_q, evp_d;

    // Integrators wrap modulo 2^W on purpose; the comb differences undo the wrap.
    always_comb begin
        i1_d  = i1_q;
        i2_d  = i2_q;
        i3_d  = i3_q;
        cnt_d = cnt_q;
        ev    = 1'b0;
        if (IN_EN) begin
            i1_d  = i1_q + (PDM_IN ? STEP_POS : STEP_NEG);
            i2_d  = i2_q + i1_d;
            i3_d  = i3_q + i2_d;
            cnt_d = cnt_q + L'(1);
            ev    = (cnt_q == L'(R - 1));
        end
        evp_d = {evp_q[PD-2:0], ev};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            i1_q  <= '0;
            i2_q  <= '0;
            i3_q  <= '0;
            cnt_q <= '0;
            evp_q <= '0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            i3_q  <= i3_d;
            cnt_q <= cnt_d;
            evp_q <= evp_d;
        end
    end

    logic [W-1:0] c1, c2;
    logic signed [W-1:0] c3;

    pdm_cic_comb #(.W(W)) u_comb1 (.clk(CLK), .rst(RST), .en(ev),       .din(i3_d), .dout(c1));
    pdm_cic_comb #(.W(W)) u_comb2 (.clk(CLK), .rst(RST), .en(evp_q[0]), .din(c1),   .dout(c2));
    pdm_cic_comb #(.W(W)) u_comb3 (.clk(CLK), .rst(RST), .en(evp_q[1]), .din(c2),   .dout(c3));

    logic signed [3*L:0]         c3_clamped;
    logic signed [OUT_BITS-1:0]  scaled;
    logic signed [OUT_BITS-1:0]  out_src;
    logic                        out_load;

    always_comb begin
        c3_clamped = (3 * L + 1)'(sat(64'(c3), 3 * L + 1));
        scaled     = OUT_BITS'(c3_clamped >>> SHIFT);
    end

`ifdef PDM_DEC_DCBLOCK_EN
    localparam int DW = OUT_BITS + 2;

    logic signed [OUT_BITS-1:0] dc_x_q, dc_x_d, dc_y_q, dc_y_d;
    logic signed [DW-1:0]       dc_sum;

    always_comb begin
        dc_x_d = dc_x_q;
        dc_y_d = dc_y_q;
        dc_sum = DW'(scaled) - DW'(dc_x_q) + DW'(dc_y_q) - DW'(dc_y_q >>> DC_SHIFT);
        if (evp_q[2]) begin
            dc_x_d = scaled;
            dc_y_d = OUT_BITS'(sat(64'(dc_sum), OUT_BITS));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dc_x_q <= '0;
            dc_y_q <= '0;
        end else begin
            dc_x_q <= dc_x_d;
            dc_y_q <= dc_y_d;
        end
    end

    assign out_src  = dc_y_q;
    assign out_load = evp_q[3];
`else
    assign out_src  = scaled;
    assign out_load = evp_q[2];
`endif

    logic signed [OUT_BITS-1:0] pcm_data_q, pcm_data_d;
    logic                       pcm_valid_q, pcm_valid_d;
    logic                       overrun_q, overrun_d;

    // A load on a handshake cycle replaces the consumed sample, so it is not an overrun.
    always_comb begin
        pcm_data_d  = pcm_data_q;
        pcm_valid_d = pcm_valid_q & ~PCM_READY;
        overrun_d   = 1'b0;
        if (out_load) begin
            pcm_data_d  = out_src;
            pcm_valid_d = 1'b1;
            overrun_d   = pcm_valid_q & ~PCM_READY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign PCM_DATA  = pcm_data_q;
    assign PCM_VALID = pcm_valid_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - randomized bench against an FIR-form reference of the CIC decimator
module tb_pdm_cic_decimator;

    localparam int R        = 64;
    localparam int OB       = 16;
    localparam int DC_SHIFT = 10;
    localparam int NH       = 3 * R - 2;
`ifdef PDM_DEC_DCBLOCK_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          PDM_IN;
    logic          IN_EN;
    logic          PCM_READY;
    logic [OB-1:0] PCM_DATA;
    logic          PCM_VALID;
    logic          OVERRUN;

    always #5 CLK = ~CLK;

    pdm_cic_decimator #(.R(R), .OUT_BITS(OB), .DC_SHIFT(DC_SHIFT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PDM_IN    (PDM_IN),
        .IN_EN     (IN_EN),
        .PCM_DATA  (PCM_DATA),
        .PCM_VALID (PCM_VALID),
        .PCM_READY (PCM_READY),
        .OVERRUN   (OVERRUN)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: the CIC equals an FIR whose taps are three length-R boxes convolved.
    int h[NH];
    int xs[$];
    int cnt_m;
    int dl_v[4];
    int dl_d[4];
    int exp_valid, exp_data, exp_ovr;
    int dc_xp, dc_yp;

    function automatic int fir_now();
        int s = 0;
        for (int k = 0; k < NH; k++) begin
            int idx = xs.size() - 1 - k;
            if (idx >= 0) s += h[k] * xs[idx];
        end
        return s;
    endfunction

    function automatic int scale(input int y);
        int c = y;
        if (c > (1 << 18) - 1) c = (1 << 18) - 1;
        if (c < -(1 << 18)) c = -(1 << 18);
        return c >>> (3 * $clog2(R) + 1 - OB);
    endfunction

    task automatic step(input bit pdm, input bit en, input bit rdy, input bit rst);
        int ld, ldv, y;
        PDM_IN    = pdm;
        IN_EN     = en;
        PCM_READY = rdy;
        RST       = rst;
        @(posedge CLK);
        if (rst) begin
            xs.delete();
            cnt_m = 0;
            for (int i = 0; i < 4; i++) begin dl_v[i] = 0; dl_d[i] = 0; end
            exp_valid = 0; exp_data = 0; exp_ovr = 0;
            dc_xp = 0; dc_yp = 0;
        end else begin
            ld  = dl_v[LAT-2];
            ldv = dl_d[LAT-2];
            for (int i = LAT - 2; i > 0; i--) begin dl_v[i] = dl_v[i-1]; dl_d[i] = dl_d[i-1]; end
            dl_v[0] = 0;
            if (en) begin
                xs.push_back(pdm ? 1 : -1);
                if (cnt_m == R - 1) begin
                    dl_v[0] = 1;
                    dl_d[0] = scale(fir_now());
                    cnt_m   = 0;
                end else begin
                    cnt_m++;
                end
            end
            if (ld != 0) begin
                y = ldv;
`ifdef PDM_DEC_DCBLOCK_EN
                y = ldv - dc_xp + dc_yp - (dc_yp >>> DC_SHIFT);
                if (y > 32767) y = 32767;
                if (y < -32768) y = -32768;
                dc_xp = ldv;
                dc_yp = y;
`endif
                exp_ovr   = (exp_valid != 0 && !rdy) ? 1 : 0;
                exp_valid = 1;
                exp_data  = y;
            end else begin
                exp_ovr = 0;
                if (rdy) exp_valid = 0;
            end
        end
        #1;
        check("pcm_valid", PCM_VALID, exp_valid);
        check("overrun", OVERRUN, exp_ovr);
        check("pcm_data", $signed(PCM_DATA), exp_data);
    endtask

    initial begin
        int h2[2*R-1];
        for (int k = 0; k < 2 * R - 1; k++) h2[k] = 0;
        for (int a = 0; a < R; a++) for (int b = 0; b < R; b++) h2[a+b]++;
        for (int k = 0; k < NH; k++) begin
            h[k] = 0;
            for (int j = 0; j < 2 * R - 1; j++) if (k - j >= 0 && k - j < R) h[k] += h2[j];
        end
        cnt_m = 0; exp_valid = 0; exp_data = 0; exp_ovr = 0; dc_xp = 0; dc_yp = 0;
        for (int i = 0; i < 4; i++) begin dl_v[i] = 0; dl_d[i] = 0; end

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 6 * R; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
`ifndef PDM_DEC_DCBLOCK_EN
        check("steady_pos", $signed(PCM_DATA), 32767);
`endif
        for (int i = 0; i < 6 * R; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
`ifndef PDM_DEC_DCBLOCK_EN
        check("steady_neg", $signed(PCM_DATA), -32768);
`endif
        for (int i = 0; i < 6 * R; i++) step(bit'(i % 2 == 0), 1'b1, 1'b1, 1'b0);
`ifndef PDM_DEC_DCBLOCK_EN
        check("steady_alt", $signed(PCM_DATA), 0);
`endif
        for (int i = 0; i < 6 * R; i++) step(bit'(i % 4 != 3), 1'b1, 1'b1, 1'b0);
`ifndef PDM_DEC_DCBLOCK_EN
        check("steady_3q", $signed(PCM_DATA), 16384);
`endif
        for (int i = 0; i < 150; i++) step(bit'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(bit'($urandom_range(0, 1)), 1'b1, bit'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 15 * R; i++) step(1'b1, bit'(i % 3 == 0), 1'b1, 1'b0);
        for (int i = 0; i < 1500; i++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0), 1'b0);
        for (int i = 0; i < 37; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_data", $signed(PCM_DATA), 0);
        for (int i = 0; i < 400; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2000; i++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
